// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state encodings, cell type and cell size for the snake game
package snake_pkg;
  localparam int CELL_SIZE = 10;
  typedef enum logic [1:0] {DIR_DOWN = 2'b00, DIR_RIGHT = 2'b01, DIR_LEFT = 2'b10, DIR_UP = 2'b11} dir_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_OVER = 2'b11} state_t;
  typedef struct packed {logic [5:0] x; logic [5:0] y;} cell_t;
  function automatic dir_t rev_dir(input dir_t d);
    return dir_t'(~d);
  endfunction
endpackage

// File: rtl/snake_seg_ring.sv
// snake_seg_ring: body ring buffer with push/pop, valid mask and parallel query/collision match
module snake_seg_ring
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int START_X = 32,
  parameter int START_Y = 24,
  parameter int START_LEN = 3,
  localparam int PW = $clog2(MAX_LEN),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          init,
  input  logic          push,
  input  logic          pop,
  input  logic          excl_tail,
  input  cell_t         push_cell,
  input  cell_t         query_cell,
  input  cell_t         col_cell,
  output cell_t         head,
  output logic [LW-1:0] length,
  output logic          query_hit,
  output logic          col_hit
);
  cell_t mem [MAX_LEN];
  logic [PW-1:0] hptr;
  logic [MAX_LEN-1:0] qm, cm;
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    logic [PW-1:0] k;
    assign k = hptr - PW'(i);
    assign qm[i] = (LW'(k) < length) && (mem[i] == query_cell);
    assign cm[i] = (LW'(k) < length - LW'(excl_tail)) && (mem[i] == col_cell);
  end
  assign query_hit = |qm;
  assign col_hit = |cm;
  assign head = mem[hptr];
  always_ff @(posedge clk) begin
    if (init) begin
      hptr <= '0;
      length <= LW'(START_LEN);
      for (int i = 0; i < MAX_LEN; i++)
        mem[i] <= cell_t'({6'(START_X - (MAX_LEN - i) % MAX_LEN), 6'(START_Y)});
    end else begin
      if (push) begin
        hptr <= hptr + PW'(1);
        mem[hptr + PW'(1)] <= push_cell;
      end
      if (push && !pop) length <= length + LW'(1);
    end
  end
endmodule

// File: rtl/snake_move_scheduler.sv
// snake_move_scheduler: button/frame-driven snake mover with wall (and SNAKE_SELF_COLLIDE_EN self) collision
module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int GRID_W = 64,
  parameter int GRID_H = 48,
  parameter int MAX_LEN = 16,
  parameter int FRAMES_PER_STEP = 8,
  parameter int START_X = 32,
  parameter int START_Y = 24,
  parameter int START_LEN = 3
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iFrameTick,
  input  logic                     iUpButton,
  input  logic                     iDownButton,
  input  logic                     iLeftButton,
  input  logic                     iRightButton,
  input  logic                     iStart,
  input  logic                     iGrow,
  input  logic [5:0]               iQueryX,
  input  logic [5:0]               iQueryY,
  output logic                     oQueryHit,
  output logic [5:0]               oHeadX,
  output logic [5:0]               oHeadY,
  output logic [$clog2(MAX_LEN):0] oLength,
  output logic [1:0]               oState,
  output logic                     oGameOver,
  output logic                     oStepPulse
);
  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam int CW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  state_t state, state_nx;
  dir_t dir, next_dir, req;
  logic [3:0] s1, s2, s3, rise;
  logic [CW-1:0] fcnt;
  logic [LW-1:0] len;
  logic grow_pend, init, tick_due, wall, self_hit, go, pop, req_ok, q_match, col_hit;
  cell_t head, cand;
  assign rise = s2 & ~s3;
  assign req = rise[3] ? DIR_UP : rise[2] ? DIR_DOWN : rise[1] ? DIR_LEFT : DIR_RIGHT;
  assign req_ok = |rise && !(req == rev_dir(dir) && len > LW'(1));
  assign wall = next_dir == DIR_UP   ? head.y == 6'd0 :
                next_dir == DIR_DOWN ? head.y == 6'(GRID_H - 1) :
                next_dir == DIR_LEFT ? head.x == 6'd0 : head.x == 6'(GRID_W - 1);
  assign cand.x = next_dir == DIR_LEFT ? head.x - 6'd1 : next_dir == DIR_RIGHT ? head.x + 6'd1 : head.x;
  assign cand.y = next_dir == DIR_UP ? head.y - 6'd1 : next_dir == DIR_DOWN ? head.y + 6'd1 : head.y;
  assign pop = !(grow_pend && len < LW'(MAX_LEN));
`ifdef SNAKE_SELF_COLLIDE_EN
  assign self_hit = col_hit;
`else
  logic unused_col;
  assign unused_col = col_hit;
  assign self_hit = 1'b0;
`endif
  assign go = state == S_STEP && !wall && !self_hit;
  assign tick_due = iFrameTick && fcnt == CW'(FRAMES_PER_STEP - 1);
  assign init = iRST || (state == S_OVER && iStart);
  snake_seg_ring #(
    .MAX_LEN(MAX_LEN), .START_X(START_X), .START_Y(START_Y), .START_LEN(START_LEN)
  ) u_ring (
    .clk(iCLK), .init(init), .push(go), .pop(go && pop), .excl_tail(pop),
    .push_cell(cand), .query_cell(cell_t'({iQueryX, iQueryY})), .col_cell(cand),
    .head(head), .length(len), .query_hit(q_match), .col_hit(col_hit)
  );
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_OVER: state_nx = iStart ? S_RUN : state;
      S_RUN:          state_nx = tick_due ? S_STEP : S_RUN;
      S_STEP:         state_nx = go ? S_RUN : S_OVER;
      default:        state_nx = state;
    endcase
  end
  always_ff @(posedge iCLK) begin
    state <= iRST ? S_IDLE : state_nx;
    s1 <= iRST ? 4'b0 : {iUpButton, iDownButton, iLeftButton, iRightButton};
    s2 <= iRST ? 4'b0 : s1;
    s3 <= iRST ? 4'b0 : s2;
    oStepPulse <= !iRST && go;
    oQueryHit <= !iRST && q_match;
    if (init) begin
      dir <= DIR_RIGHT;
      next_dir <= DIR_RIGHT;
      grow_pend <= 1'b0;
      fcnt <= '0;
    end else begin
      if (state == S_STEP) dir <= next_dir;
      if (req_ok) next_dir <= req;
      if (go) grow_pend <= iGrow;
      else if (iGrow && state != S_OVER) grow_pend <= 1'b1;
      if (state == S_RUN && iFrameTick) fcnt <= tick_due ? '0 : fcnt + CW'(1);
    end
  end
  assign oHeadX = head.x;
  assign oHeadY = head.y;
  assign oLength = len;
  assign oState = state;
  assign oGameOver = state == S_OVER;
endmodule

// File: tb/tb_snake_move_scheduler.sv
// tb_snake_move_scheduler: directed self-checking bench for snake_move_scheduler
module tb_snake_move_scheduler;
  logic iCLK = 1'b0, iRST = 1'b1, iFrameTick = 1'b0, iStart = 1'b0, iGrow = 1'b0;
  logic iUpButton = 1'b0, iDownButton = 1'b0, iLeftButton = 1'b0, iRightButton = 1'b0;
  logic [5:0] iQueryX = 6'd0, iQueryY = 6'd0;
  logic oQueryHit, oGameOver, oStepPulse;
  logic [5:0] oHeadX, oHeadY;
  logic [4:0] oLength;
  logic [1:0] oState;
  int total = 0, bad = 0;
  always #5 iCLK = ~iCLK;
  snake_move_scheduler dut (
    .iCLK(iCLK), .iRST(iRST), .iFrameTick(iFrameTick),
    .iUpButton(iUpButton), .iDownButton(iDownButton), .iLeftButton(iLeftButton), .iRightButton(iRightButton),
    .iStart(iStart), .iGrow(iGrow), .iQueryX(iQueryX), .iQueryY(iQueryY),
    .oQueryHit(oQueryHit), .oHeadX(oHeadX), .oHeadY(oHeadY), .oLength(oLength),
    .oState(oState), .oGameOver(oGameOver), .oStepPulse(oStepPulse)
  );
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, "_x"}, oHeadX, x);
    chk({tag, "_y"}, oHeadY, y);
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      iFrameTick = 1'b1;
      cyc(1);
      iFrameTick = 1'b0;
      cyc(1);
    end
  endtask
  task automatic press(input logic [3:0] b);
    {iUpButton, iDownButton, iLeftButton, iRightButton} = b;
    cyc(4);
    {iUpButton, iDownButton, iLeftButton, iRightButton} = 4'b0;
    cyc(3);
  endtask
  task automatic query(input string tag, input int x, input int y, input int exp);
    iQueryX = 6'(x);
    iQueryY = 6'(y);
    cyc(1);
    chk(tag, oQueryHit, exp);
  endtask
  task automatic start();
    iStart = 1'b1;
    cyc(1);
    iStart = 1'b0;
  endtask
  task automatic grow_step();
    iGrow = 1'b1;
    cyc(1);
    iGrow = 1'b0;
    frames(8);
  endtask
  initial begin
    cyc(3);
    chk("rst_state", oState, 0);
    chk_head("rst_head", 32, 24);
    chk("rst_len", oLength, 3);
    chk("rst_over", oGameOver, 0);
    chk("rst_pulse", oStepPulse, 0);
    chk("rst_qhit", oQueryHit, 0);
    iRST = 1'b0;
    cyc(1);
    start();
    chk("run_state", oState, 1);
    frames(7);
    chk_head("no_step_7", 32, 24);
    frames(1);
    chk("step_pulse", oStepPulse, 1);
    chk_head("step1", 33, 24);
    chk("step1_len", oLength, 3);
    cyc(1);
    chk("pulse_one_cycle", oStepPulse, 0);
    query("q30", 30, 24, 0);
    query("q31", 31, 24, 1);
    query("q33", 33, 24, 1);
    press(4'b0010);
    frames(8);
    chk_head("rev_dropped", 34, 24);
    press(4'b1000);
    frames(8);
    chk_head("turn_up", 34, 23);
    press(4'b1010);
    frames(8);
    chk_head("up_over_left", 34, 22);
    press(4'b0001);
    frames(8);
    chk_head("turn_right", 35, 22);
    repeat (28) frames(8);
    chk_head("at_wall", 63, 22);
    frames(8);
    chk("wall_state", oState, 3);
    chk("wall_over", oGameOver, 1);
    chk("wall_pulse", oStepPulse, 0);
    chk_head("wall_head", 63, 22);
    chk("wall_len", oLength, 3);
    query("wall_q61", 61, 22, 1);
    query("wall_q60", 60, 22, 0);
    frames(8);
    chk_head("over_hold", 63, 22);
    start();
    chk("restart_state", oState, 1);
    chk_head("restart_head", 32, 24);
    chk("restart_len", oLength, 3);
    for (int i = 0; i < 13; i++) begin
      grow_step();
      chk("grow_len", oLength, 4 + i);
    end
    chk_head("grown_head", 45, 24);
    grow_step();
    chk("grow_sat", oLength, 16);
    repeat (4) frames(8);
    chk_head("wrap_head", 50, 24);
    chk("wrap_len", oLength, 16);
    query("wrap_q50", 50, 24, 1);
    query("wrap_q42", 42, 24, 1);
    query("wrap_q35", 35, 24, 1);
    query("wrap_q34", 34, 24, 0);
    iRST = 1'b1;
    cyc(2);
    iRST = 1'b0;
    start();
    grow_step();
    grow_step();
    chk("sc_len", oLength, 5);
    chk_head("sc_h0", 34, 24);
    press(4'b1000);
    frames(8);
    chk_head("sc_up", 34, 23);
    press(4'b0010);
    frames(8);
    chk_head("sc_left", 33, 23);
    press(4'b0100);
    frames(8);
`ifdef SNAKE_SELF_COLLIDE_EN
    chk("sc_state", oState, 3);
    chk("sc_over", oGameOver, 1);
    chk_head("sc_head", 33, 23);
`else
    chk("sc_state", oState, 1);
    chk("sc_over", oGameOver, 0);
    chk_head("sc_head", 33, 24);
    chk("sc_len5", oLength, 5);
    query("sc_q33_24", 33, 24, 1);
    query("sc_q34_24", 34, 24, 1);
    query("sc_q32_24", 32, 24, 0);
`endif
    iRST = 1'b1;
    cyc(2);
    iRST = 1'b0;
    start();
    frames(7);
    iFrameTick = 1'b1;
    cyc(1);
    iFrameTick = 1'b0;
    chk("mid_step_state", oState, 2);
    iRST = 1'b1;
    cyc(1);
    chk("rst_in_step_state", oState, 0);
    chk("rst_in_step_pulse", oStepPulse, 0);
    chk_head("rst_in_step_head", 32, 24);
    iRST = 1'b0;
    cyc(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
